// File: rtl/seg7_pkg.sv
// Shared segment encodings and width helper for the seven-segment scan driver.
// Segment vectors are {a,b,c,d,e,f,g} with bit 6 = a, active low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_HEX [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  // Ceiling log2 with a floor of 1 so single-value counters still get a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low segment decoder with hex/BCD
// selection and a forced-blank input.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && ((code < 4'd10) || hex_en)) seg = SEG_HEX[code];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver: per-frame input
// snapshot, leading-zero blanking and a blank cycle at each digit switch.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_en,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned CNT_W = clog2(CLK_DIV);
  localparam int unsigned IDX_W = clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_hex;
  logic                    sh_lzb;

  logic                    tick;
  logic                    load;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_an;
  logic [6:0]              dec_seg;

  assign tick = (div_cnt == CNT_LAST);
  // Snapshot on the first clock after reset and at every frame wrap.
  assign load = first_q || (tick && (idx == IDX_LAST));

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    lz_blank = '0;
    zero_run = sh_lzb;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zero_run = zero_run && (sh_digits[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      if (j != NUM_DIGITS - 1) lz_blank[NUM_DIGITS-1-j] = zero_run;
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_an    = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code  = sh_digits[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = lz_blank[i];
        cur_an[i] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .code   (cur_code),
    .hex_en (sh_hex),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      idx       <= '0;
      first_q   <= 1'b1;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_hex    <= 1'b0;
      sh_lzb    <= 1'b0;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
      an        <= '1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      first_q <= 1'b0;
      if (load) begin
        sh_digits <= digits;
        sh_dp     <= dp_in;
        sh_hex    <= hex_en;
        sh_lzb    <= lzb_en;
      end
      // Slot cycle 0 is the anti-ghost gap: everything off.
      if (div_cnt == '0) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= dec_seg;
        dp  <= ~cur_dp | cur_blank;
        an  <= cur_an;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed table-driven bench for seg7_scan_mux with 1-, 4- and 8-digit
// instances plus a full-size prescaler instance for async reset.
module tb_seg7_scan_mux;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000;

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dp_in;
    logic            hex_en;
    logic            lzb_en;
    logic [3:0][6:0] seg_exp;  // element k = digit k
    logic [3:0]      dp_exp;   // active-low dp expected per digit
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rb_n = 1'b0;
  logic mon_en = 1'b0;

  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        hex_en = 1'b0;
  logic        lzb_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;

  logic [6:0]  seg8;
  logic        dp8;
  logic [7:0]  an8;

  logic [6:0]  segb;
  logic        dpb;
  logic [3:0]  anb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .digits(digits), .dp_in(dp_in),
    .hex_en(hex_en), .lzb_en(lzb_en), .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan_mux #(.NUM_DIGITS(1), .CLK_DIV(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .digits(4'h5), .dp_in(1'b1),
    .hex_en(1'b0), .lzb_en(1'b1), .seg(seg1), .dp(dp1), .an(an1)
  );

  seg7_scan_mux #(.NUM_DIGITS(8), .CLK_DIV(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .digits(32'h87654321), .dp_in(8'h00),
    .hex_en(1'b0), .lzb_en(1'b0), .seg(seg8), .dp(dp8), .an(an8)
  );

  seg7_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(50000)) dutb (
    .clk(clk), .reset_n(rb_n), .digits(16'h1234), .dp_in(4'b0000),
    .hex_en(1'b0), .lzb_en(1'b0), .seg(segb), .dp(dpb), .an(anb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle; released mid-cycle so the next edge is edge 1.
  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("reset_state", {an, seg, dp}, {4'hF, B, 1'b1});
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ($countones(~an) > 1 || $countones(~an8) > 1 || $countones(~anb) > 1) begin
        bad++;
        $display("FAIL onehot: an=%b an8=%b anb=%b, at most one low allowed", an, an8, anb);
      end
    end
  end

  vec_t vecs [8];

  initial begin
    logic [3:0]  oh4;
    logic [7:0]  oh8;
    logic [6:0]  seg_ref [10];
    logic [6:0]  exp_seg;
    int          slot;
    int          pos;

    seg_ref = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, {S1, S2, S3, S4}, 4'b1111};
    vecs[1] = '{16'h00A5, 4'b0000, 1'b0, 1'b1, {B,  B,  B,  S5}, 4'b1111};
    vecs[2] = '{16'h00A5, 4'b1111, 1'b1, 1'b1, {B,  B,  SA, S5}, 4'b1100};
    vecs[3] = '{16'h0000, 4'b1111, 1'b0, 1'b1, {B,  B,  B,  S0}, 4'b1110};
    vecs[4] = '{16'hFEDC, 4'b0101, 1'b1, 1'b0, {SF, SE, SD, SC}, 4'b1010};
    vecs[5] = '{16'h0700, 4'b1111, 1'b0, 1'b1, {B,  S7, S0, S0}, 4'b1000};
    vecs[6] = '{16'h0B09, 4'b0000, 1'b0, 1'b1, {B,  B,  S0, S9}, 4'b1111};
    vecs[7] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {S0, S0, S0, S0}, 4'b1111};

    repeat (2) @(posedge clk);
    #1 check("reset_hold", {an, seg, dp}, {4'hF, B, 1'b1});

    for (int v = 0; v < 8; v++) begin
      digits = vecs[v].digits;
      dp_in  = vecs[v].dp_in;
      hex_en = vecs[v].hex_en;
      lzb_en = vecs[v].lzb_en;
      do_reset();
      mon_en = 1'b1;
      for (int c = 0; c < 32; c++) begin
        step();
        slot = (c % 16) / 4;
        pos  = c % 4;
        oh4  = 4'b0001 << slot;
        if (pos == 0)
          check($sformatf("vec%0d_c%0d", v, c), {an, seg, dp}, {4'hF, B, 1'b1});
        else
          check($sformatf("vec%0d_c%0d", v, c), {an, seg, dp},
                {~oh4, vecs[v].seg_exp[slot], vecs[v].dp_exp[slot]});
      end
    end

    // Mid-frame input change: held until the next frame boundary.
    digits = 16'h1111; dp_in = '0; hex_en = 1'b0; lzb_en = 1'b0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      step();
      if (c == 4) digits = 16'h2222;
      slot = (c % 16) / 4;
      pos  = c % 4;
      oh4  = 4'b0001 << slot;
      exp_seg = (c < 16) ? S1 : S2;
      if (pos == 0)
        check($sformatf("midframe_c%0d", c), {an, seg, dp}, {4'hF, B, 1'b1});
      else
        check($sformatf("midframe_c%0d", c), {an, seg, dp}, {~oh4, exp_seg, 1'b1});
    end

    // Single-digit and eight-digit instances from a common reset.
    do_reset();
    for (int c = 0; c < 48; c++) begin
      step();
      if (c < 12) begin
        if (c % 4 == 0)
          check($sformatf("n1_c%0d", c), {an1, seg1, dp1}, {1'b1, B, 1'b1});
        else
          check($sformatf("n1_c%0d", c), {an1, seg1, dp1}, {1'b0, S5, 1'b0});
      end
      slot = (c % 24) / 3;
      pos  = c % 3;
      oh8  = 8'b0000_0001 << slot;
      if (pos == 0)
        check($sformatf("n8_c%0d", c), {an8, seg8, dp8}, {8'hFF, B, 1'b1});
      else
        check($sformatf("n8_c%0d", c), {an8, seg8, dp8}, {~oh8, seg_ref[slot+1], 1'b1});
    end

    // Full-size prescaler: asynchronous reset mid-slot, then restart.
    @(posedge clk);
    #1 rb_n = 1'b1;
    step();
    check("big_first_blank", {anb, segb, dpb}, {4'hF, B, 1'b1});
    step();
    check("big_first_lit", {anb, segb, dpb}, {4'b1110, S4, 1'b1});
    repeat (100) step();
    check("big_mid_slot", {anb, segb, dpb}, {4'b1110, S4, 1'b1});
    #1 rb_n = 1'b0;
    #1 check("big_async_reset", {anb, segb, dpb}, {4'hF, B, 1'b1});
    @(posedge clk);
    #2 rb_n = 1'b1;
    step();
    check("big_restart_blank", {anb, segb, dpb}, {4'hF, B, 1'b1});
    step();
    check("big_restart_lit", {anb, segb, dpb}, {4'b1110, S4, 1'b1});

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
